// File: rtl/io_device_port_if.sv
// Byte-wide processor I/O handshake bundle.
// slave  : the external device endpoint (io_device_port).
// master : the processor side that presents acks and output bytes.
interface io_device_port_if;
  logic [7:0] input_bus;
  logic       in_dev_hs;
  logic       in_dev_ack;
  logic [7:0] output_bus;
  logic       out_req;
  logic       out_dev_hs;
  logic       out_dev_ack;

  modport master (
    input  input_bus, in_dev_hs, out_dev_hs, out_dev_ack,
    output in_dev_ack, output_bus, out_req
  );

  modport slave (
    output input_bus, in_dev_hs, out_dev_hs, out_dev_ack,
    input  in_dev_ack, output_bus, out_req
  );
endinterface

// File: rtl/io_device_port.sv
// Device-side endpoint for the processor byte I/O handshake.
// A TX FIFO (host -> processor) feeds a 4-phase presenter; a 4-phase
// receiver fills an RX FIFO (processor -> host). All outputs registered.
//
// state      | meaning
// I_IDLE     | nothing offered; waits for TX FIFO to hold a byte
// I_PRESENT  | head byte on input_bus with in_dev_hs high, waits for ack
// I_WAIT_REL | byte popped, waits for the processor to drop in_dev_ack
// O_READY    | out_dev_hs mirrors !rx_full; captures on out_req
// O_ACK      | out_dev_ack high until the processor drops out_req
module io_device_port #(
  parameter int DEPTH = 4
) (
  input  logic                     g_clk,
  input  logic                     g_clr,
  input  logic                     host_wr_en,
  input  logic [7:0]               host_wr_data,
  input  logic                     host_rd_en,
  output logic [7:0]               host_rd_data,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     tx_full,
  output logic                     rx_empty,
  output logic                     host_err,
  io_device_port_if.slave          proc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {I_IDLE, I_PRESENT, I_WAIT_REL} in_state_e;
  typedef enum logic       {O_READY, O_ACK}                out_state_e;

  in_state_e  in_state_q,  in_state_d;
  out_state_e out_state_q, out_state_d;

  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          tx_full_q, tx_full_d, rx_empty_q, rx_empty_d;
  logic          err_q, err_d;
  logic [7:0]    in_bus_q, in_bus_d, rd_data_q, rd_data_d;
  logic          in_hs_q, in_hs_d, out_hs_q, out_hs_d, out_ack_q, out_ack_d;
  logic          tx_push, tx_pop, rx_push, rx_pop;

  // Next-state for both FIFOs, both handshake FSMs and the sticky error.
  always_comb begin
    tx_pop  = (in_state_q == I_PRESENT) && proc.in_dev_ack;
    // a pop in the same cycle frees the slot, so a write when full is legal then
    tx_push = host_wr_en && (!tx_full_q || tx_pop);
    rx_push = (out_state_q == O_READY) && out_hs_q && proc.out_req;
    rx_pop  = host_rd_en && !rx_empty_q;

    tx_wr_d     = tx_wr_q;
    tx_rd_d     = tx_rd_q;
    rx_wr_d     = rx_wr_q;
    rx_rd_d     = rx_rd_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    rd_data_d   = rd_data_q;
    in_state_d  = in_state_q;
    out_state_d = out_state_q;
    in_bus_d    = in_bus_q;
    in_hs_d     = in_hs_q;
    out_hs_d    = out_hs_q;
    out_ack_d   = out_ack_q;

    if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
    if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
    if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
    if (rx_pop) begin
      rx_rd_d   = rx_rd_q + 1'b1;
      rd_data_d = rx_mem_q[rx_rd_q];
    end

    unique case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    unique case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase

    tx_full_d  = (tx_cnt_d == FULL_CNT);
    rx_empty_d = (rx_cnt_d == '0);
    err_d      = err_q | (host_wr_en && !tx_push) | (host_rd_en && rx_empty_q);

    unique case (in_state_q)
      I_IDLE: begin
        if (tx_cnt_q != '0) begin
          in_bus_d   = tx_mem_q[tx_rd_q];
          in_hs_d    = 1'b1;
          in_state_d = I_PRESENT;
        end
      end
      I_PRESENT: begin
        if (proc.in_dev_ack) begin
          in_hs_d    = 1'b0;
          in_state_d = I_WAIT_REL;
        end
      end
      I_WAIT_REL: begin
        if (!proc.in_dev_ack) in_state_d = I_IDLE;
      end
      default: in_state_d = I_IDLE;
    endcase

    unique case (out_state_q)
      O_READY: begin
        if (rx_push) begin
          out_ack_d   = 1'b1;
          out_hs_d    = 1'b0;
          out_state_d = O_ACK;
        end else begin
          // looks at the post-edge count so a host pop from full reopens at once
          out_hs_d = (rx_cnt_d != FULL_CNT);
        end
      end
      O_ACK: begin
        if (!proc.out_req) begin
          out_ack_d   = 1'b0;
          out_state_d = O_READY;
        end
      end
      default: out_state_d = O_READY;
    endcase
  end

  // Register all control state and outputs; synchronous active-low clear.
  always_ff @(posedge g_clk) begin
    if (!g_clr) begin
      in_state_q  <= I_IDLE;
      out_state_q <= O_READY;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      tx_full_q   <= 1'b0;
      rx_empty_q  <= 1'b1;
      err_q       <= 1'b0;
      in_bus_q    <= 8'h00;
      rd_data_q   <= 8'h00;
      in_hs_q     <= 1'b0;
      out_hs_q    <= 1'b0;
      out_ack_q   <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_full_q   <= tx_full_d;
      rx_empty_q  <= rx_empty_d;
      err_q       <= err_d;
      in_bus_q    <= in_bus_d;
      rd_data_q   <= rd_data_d;
      in_hs_q     <= in_hs_d;
      out_hs_q    <= out_hs_d;
      out_ack_q   <= out_ack_d;
    end
  end

  // FIFO storage; stale entries are harmless since pointers reset.
  always_ff @(posedge g_clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= host_wr_data;
    if (rx_push) rx_mem_q[rx_wr_q] <= proc.output_bus;
  end

  assign host_rd_data     = rd_data_q;
  assign tx_count         = tx_cnt_q;
  assign rx_count         = rx_cnt_q;
  assign tx_full          = tx_full_q;
  assign rx_empty         = rx_empty_q;
  assign host_err         = err_q;
  assign proc.input_bus   = in_bus_q;
  assign proc.in_dev_hs   = in_hs_q;
  assign proc.out_dev_hs  = out_hs_q;
  assign proc.out_dev_ack = out_ack_q;

endmodule

// File: tb/tb_io_device_port.sv
// Bench for io_device_port: directed scenarios followed by a randomized
// host/processor mix checked against queue-based FIFO models.
module tb_io_device_port;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          g_clk = 1'b0;
  logic          g_clr;
  logic          host_wr_en;
  logic [7:0]    host_wr_data;
  logic          host_rd_en;
  logic [7:0]    host_rd_data;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic          tx_full;
  logic          rx_empty;
  logic          host_err;

  io_device_port_if pif();

  io_device_port #(.DEPTH(DEPTH)) dut (
    .g_clk        (g_clk),
    .g_clr        (g_clr),
    .host_wr_en   (host_wr_en),
    .host_wr_data (host_wr_data),
    .host_rd_en   (host_rd_en),
    .host_rd_data (host_rd_data),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .tx_full      (tx_full),
    .rx_empty     (rx_empty),
    .host_err     (host_err),
    .proc         (pif)
  );

  always #5 g_clk = ~g_clk;

  int checks = 0;
  int errors = 0;

  byte unsigned tx_q[$];
  byte unsigned rx_q[$];
  logic         exp_err;
  logic [7:0]   exp_rd;
  logic         hs_in, hs_out, ack_out, tx_pop, rx_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_wr_en     = 1'b0;
    host_wr_data   = 8'h00;
    host_rd_en     = 1'b0;
    pif.in_dev_ack = 1'b0;
    pif.out_req    = 1'b0;
    pif.output_bus = 8'h00;
  endtask

  // processor takes one byte from the device, expecting value b
  task automatic drain_one(input logic [7:0] b);
    int n = 0;
    while (pif.in_dev_hs !== 1'b1 && n < 20) begin step(); n++; end
    chk("drain_hs_wait", {31'd0, pif.in_dev_hs}, 1);
    chk("drain_data", {24'd0, pif.input_bus}, {24'd0, b});
    pif.in_dev_ack = 1'b1;
    step();
    chk("drain_hs_drop", {31'd0, pif.in_dev_hs}, 0);
    pif.in_dev_ack = 1'b0;
    step();
  endtask

  // processor sends one byte to the device
  task automatic proc_send(input logic [7:0] b);
    int n = 0;
    while (pif.out_dev_hs !== 1'b1 && n < 20) begin step(); n++; end
    chk("send_hs_wait", {31'd0, pif.out_dev_hs}, 1);
    pif.output_bus = b;
    pif.out_req    = 1'b1;
    step();
    chk("send_ack", {31'd0, pif.out_dev_ack}, 1);
    pif.out_req = 1'b0;
    step();
    chk("send_ack_drop", {31'd0, pif.out_dev_ack}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset with random inputs ----------------
    g_clr = 1'b0;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      host_wr_en     = 1'($urandom);
      host_wr_data   = 8'($urandom);
      host_rd_en     = 1'($urandom);
      pif.in_dev_ack = 1'($urandom);
      pif.out_req    = 1'($urandom);
      pif.output_bus = 8'($urandom);
      step();
    end
    chk("rst_input_bus", {24'd0, pif.input_bus}, 0);
    chk("rst_rd_data", {24'd0, host_rd_data}, 0);
    chk("rst_in_hs", {31'd0, pif.in_dev_hs}, 0);
    chk("rst_out_hs", {31'd0, pif.out_dev_hs}, 0);
    chk("rst_out_ack", {31'd0, pif.out_dev_ack}, 0);
    chk("rst_err", {31'd0, host_err}, 0);
    chk("rst_tx_count", 32'(tx_count), 0);
    chk("rst_rx_count", 32'(rx_count), 0);
    chk("rst_tx_full", {31'd0, tx_full}, 0);
    chk("rst_rx_empty", {31'd0, rx_empty}, 1);
    idle_inputs();
    g_clr = 1'b1;
    step();
    chk("rel_out_hs", {31'd0, pif.out_dev_hs}, 1);
    chk("rel_in_hs", {31'd0, pif.in_dev_hs}, 0);

    // ---------------- TX ordering ----------------
    host_wr_en   = 1'b1;
    host_wr_data = 8'h5A;
    step();
    chk("tx_cnt_after_w1", 32'(tx_count), 1);
    chk("tx_hs_not_yet", {31'd0, pif.in_dev_hs}, 0);
    host_wr_data = 8'hC3;
    step();
    host_wr_en = 1'b0;
    chk("tx_hs_5a", {31'd0, pif.in_dev_hs}, 1);
    chk("tx_bus_5a", {24'd0, pif.input_bus}, 32'h5A);
    chk("tx_cnt_2", 32'(tx_count), 2);
    step();
    chk("tx_hold_hs", {31'd0, pif.in_dev_hs}, 1);
    chk("tx_hold_bus", {24'd0, pif.input_bus}, 32'h5A);
    pif.in_dev_ack = 1'b1;
    step();
    chk("tx_ack_hs_drop", {31'd0, pif.in_dev_hs}, 0);
    chk("tx_ack_cnt", 32'(tx_count), 1);
    pif.in_dev_ack = 1'b0;
    step();
    chk("tx_c3_not_early", {31'd0, pif.in_dev_hs}, 0);
    step();
    chk("tx_hs_c3", {31'd0, pif.in_dev_hs}, 1);
    chk("tx_bus_c3", {24'd0, pif.input_bus}, 32'hC3);
    step();
    pif.in_dev_ack = 1'b1;
    step();
    chk("tx_c3_hs_drop", {31'd0, pif.in_dev_hs}, 0);
    chk("tx_cnt_0", 32'(tx_count), 0);
    pif.in_dev_ack = 1'b0;
    step();
    step();
    chk("tx_idle_cnt", 32'(tx_count), 0);
    chk("tx_idle_hs", {31'd0, pif.in_dev_hs}, 0);
    chk("tx_idle_bus_kept", {24'd0, pif.input_bus}, 32'hC3);

    // ---------------- RX path ----------------
    pif.output_bus = 8'h81;
    pif.out_req    = 1'b1;
    step();
    chk("rx_ack", {31'd0, pif.out_dev_ack}, 1);
    chk("rx_hs_drop", {31'd0, pif.out_dev_hs}, 0);
    chk("rx_cnt_1", 32'(rx_count), 1);
    chk("rx_not_empty", {31'd0, rx_empty}, 0);
    pif.out_req = 1'b0;
    step();
    chk("rx_ack_drop", {31'd0, pif.out_dev_ack}, 0);
    chk("rx_hs_still_low", {31'd0, pif.out_dev_hs}, 0);
    step();
    chk("rx_hs_back", {31'd0, pif.out_dev_hs}, 1);
    host_rd_en = 1'b1;
    step();
    host_rd_en = 1'b0;
    chk("rx_rd_data", {24'd0, host_rd_data}, 32'h81);
    chk("rx_empty_again", {31'd0, rx_empty}, 1);
    chk("rx_cnt_0", 32'(rx_count), 0);
    chk("rx_no_err", {31'd0, host_err}, 0);

    // ---------------- TX overflow ----------------
    for (int i = 1; i <= 5; i++) begin
      host_wr_en   = 1'b1;
      host_wr_data = 8'(i);
      step();
      if (i == 3) chk("ovf_not_full_3", {31'd0, tx_full}, 0);
      if (i == 4) chk("ovf_full_4", {31'd0, tx_full}, 1);
    end
    host_wr_en = 1'b0;
    chk("ovf_cnt", 32'(tx_count), DEPTH);
    chk("ovf_err", {31'd0, host_err}, 1);
    chk("ovf_bus_01", {24'd0, pif.input_bus}, 32'h01);
    chk("ovf_hs", {31'd0, pif.in_dev_hs}, 1);
    // write while full but with a pop in the same cycle is accepted
    host_wr_en     = 1'b1;
    host_wr_data   = 8'h06;
    pif.in_dev_ack = 1'b1;
    step();
    host_wr_en = 1'b0;
    chk("simul_cnt", 32'(tx_count), DEPTH);
    chk("simul_full", {31'd0, tx_full}, 1);
    chk("simul_hs", {31'd0, pif.in_dev_hs}, 0);
    pif.in_dev_ack = 1'b0;
    step();
    drain_one(8'h02);
    drain_one(8'h03);
    drain_one(8'h04);
    drain_one(8'h06);
    chk("ovf_drained", 32'(tx_count), 0);
    chk("ovf_unfull", {31'd0, tx_full}, 0);
    chk("err_sticky", {31'd0, host_err}, 1);

    // ---------------- RX full ----------------
    proc_send(8'hA1);
    proc_send(8'hA2);
    proc_send(8'hA3);
    proc_send(8'hA4);
    step();
    chk("rxf_hs_low", {31'd0, pif.out_dev_hs}, 0);
    chk("rxf_cnt", 32'(rx_count), DEPTH);
    pif.output_bus = 8'h55;
    pif.out_req    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rxf_no_ack", {31'd0, pif.out_dev_ack}, 0);
      chk("rxf_hs_stays_low", {31'd0, pif.out_dev_hs}, 0);
    end
    host_rd_en = 1'b1;
    step();
    host_rd_en = 1'b0;
    chk("rxf_rd_a1", {24'd0, host_rd_data}, 32'hA1);
    chk("rxf_cnt_3", 32'(rx_count), DEPTH - 1);
    chk("rxf_hs_reopen", {31'd0, pif.out_dev_hs}, 1);
    step();
    chk("rxf_5th_ack", {31'd0, pif.out_dev_ack}, 1);
    chk("rxf_5th_cnt", 32'(rx_count), DEPTH);
    pif.out_req = 1'b0;
    step();
    chk("rxf_5th_ack_drop", {31'd0, pif.out_dev_ack}, 0);
    begin
      logic [7:0] exp_bytes [4];
      exp_bytes[0] = 8'hA2; exp_bytes[1] = 8'hA3;
      exp_bytes[2] = 8'hA4; exp_bytes[3] = 8'h55;
      for (int i = 0; i < 4; i++) begin
        host_rd_en = 1'b1;
        step();
        chk("rxf_order", {24'd0, host_rd_data}, {24'd0, exp_bytes[i]});
      end
      host_rd_en = 1'b0;
    end
    chk("rxf_empty", {31'd0, rx_empty}, 1);

    // ---------------- reset mid-handshake ----------------
    host_wr_en     = 1'b1;
    host_wr_data   = 8'h11;
    pif.output_bus = 8'h99;
    pif.out_req    = 1'b1;
    step();
    host_wr_data = 8'h22;
    step();
    host_wr_data = 8'h33;
    step();
    host_wr_en = 1'b0;
    chk("mid_in_hs", {31'd0, pif.in_dev_hs}, 1);
    chk("mid_tx_cnt", 32'(tx_count), 3);
    chk("mid_out_ack", {31'd0, pif.out_dev_ack}, 1);
    chk("mid_rx_cnt", 32'(rx_count), 1);
    g_clr = 1'b0;
    step();
    chk("mid_rst_in_hs", {31'd0, pif.in_dev_hs}, 0);
    chk("mid_rst_out_ack", {31'd0, pif.out_dev_ack}, 0);
    chk("mid_rst_tx_cnt", 32'(tx_count), 0);
    chk("mid_rst_rx_cnt", 32'(rx_count), 0);
    chk("mid_rst_out_hs", {31'd0, pif.out_dev_hs}, 0);
    chk("mid_rst_bus", {24'd0, pif.input_bus}, 0);
    chk("mid_rst_err", {31'd0, host_err}, 0);
    chk("mid_rst_empty", {31'd0, rx_empty}, 1);
    g_clr       = 1'b1;
    pif.out_req = 1'b0;
    step();
    chk("mid_rel_out_hs", {31'd0, pif.out_dev_hs}, 1);
    step();
    chk("mid_discarded", {31'd0, pif.in_dev_hs}, 0);
    host_rd_en = 1'b1;
    step();
    host_rd_en = 1'b0;
    chk("empty_rd_err", {31'd0, host_err}, 1);
    chk("empty_rd_hold", {24'd0, host_rd_data}, 0);

    // ---------------- randomized traffic vs queue model ----------------
    idle_inputs();
    g_clr = 1'b0;
    step();
    g_clr = 1'b1;
    step();
    tx_q.delete();
    rx_q.delete();
    exp_err = 1'b0;
    exp_rd  = 8'h00;
    for (int cyc = 0; cyc < 500; cyc++) begin
      chk("r_tx_count", 32'(tx_count), tx_q.size());
      chk("r_rx_count", 32'(rx_count), rx_q.size());
      chk("r_tx_full", {31'd0, tx_full}, {31'd0, (tx_q.size() == DEPTH)});
      chk("r_rx_empty", {31'd0, rx_empty}, {31'd0, (rx_q.size() == 0)});
      chk("r_err", {31'd0, host_err}, {31'd0, exp_err});
      chk("r_rd_data", {24'd0, host_rd_data}, {24'd0, exp_rd});
      if (rx_q.size() == DEPTH) chk("r_full_blocks_hs", {31'd0, pif.out_dev_hs}, 0);

      hs_in   = pif.in_dev_hs;
      hs_out  = pif.out_dev_hs;
      ack_out = pif.out_dev_ack;

      // processor input side: ack a presented byte after a random delay
      if (pif.in_dev_ack) begin
        if ($urandom_range(0, 1) == 1) pif.in_dev_ack = 1'b0;
      end else if (hs_in && $urandom_range(0, 2) == 0) begin
        pif.in_dev_ack = 1'b1;
      end
      tx_pop = pif.in_dev_ack && hs_in;
      if (tx_pop) begin
        chk("r_present_nonempty", {31'd0, (tx_q.size() != 0)}, 1);
        if (tx_q.size() != 0) begin
          chk("r_present_data", {24'd0, pif.input_bus}, {24'd0, tx_q[0]});
          void'(tx_q.pop_front());
        end
      end

      // host write side
      host_wr_en   = ($urandom_range(0, 2) != 0);
      host_wr_data = 8'($urandom);
      if (host_wr_en) begin
        if (tx_q.size() < DEPTH) tx_q.push_back(host_wr_data);
        else exp_err = 1'b1;
      end

      // processor output side: raise req with fresh data, drop after ack
      if (pif.out_req) begin
        if (ack_out && $urandom_range(0, 1) == 1) pif.out_req = 1'b0;
      end else if (!ack_out && $urandom_range(0, 2) == 0) begin
        pif.out_req    = 1'b1;
        pif.output_bus = 8'($urandom);
      end
      rx_push = pif.out_req && hs_out;

      // host read side
      host_rd_en = ($urandom_range(0, 3) == 0);
      if (host_rd_en) begin
        if (rx_q.size() != 0) exp_rd = rx_q.pop_front();
        else exp_err = 1'b1;
      end
      if (rx_push) rx_q.push_back(pif.output_bus);

      step();
    end

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
